timer_bank_ise: RTL



---
 rtl/timer_bank_ise.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/timer_bank_ise.sv
// rtl/timer_bank_ise.sv - multi-channel microsecond timer custom instruction on a shared 1 us tick
// Macro TIMER_BANK_PERIODIC_EN adds opcode 6 (periodic auto-reload channels).
module timer_bank_ise #(
   parameter int         clockFrequencyInHz  = 50000000,
   parameter int         nrOfChannels        = 4,
   parameter int         counterWidth        = 32,
   parameter logic [7:0] customInstructionId = 8'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ciStart,
   input  logic        ciCke,
   input  logic [7:0]  ciN,
   input  logic [31:0] ciValueA,
   input  logic [31:0] ciValueB,
   output logic        ciDone,
   output logic [31:0] ciResult
);
   localparam int PRE_MAX = clockFrequencyInHz / 1000000 - 1;
   localparam int PRE_W   = $clog2(PRE_MAX + 1);
   localparam logic [PRE_W-1:0]        PRE_RELOAD = PRE_W'(PRE_MAX);
   localparam logic [PRE_W-1:0]        PRE_ONE    = PRE_W'(1);
   localparam logic [counterWidth-1:0] CNT_ONE    = counterWidth'(1);

   localparam logic [3:0] OP_WAIT     = 4'd0;
   localparam logic [3:0] OP_START    = 4'd1;
   localparam logic [3:0] OP_READ     = 4'd2;
   localparam logic [3:0] OP_JOIN     = 4'd3;
   localparam logic [3:0] OP_CANCEL   = 4'd4;
   localparam logic [3:0] OP_STATUS   = 4'd5;
`ifdef TIMER_BANK_PERIODIC_EN
   localparam logic [3:0] OP_PERIODIC = 4'd6;
`endif

   typedef enum logic [1:0] {S_IDLE, S_BLOCK, S_DONE} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [PRE_W-1:0]        r_pre;
   logic                    w_tick;
   logic [counterWidth-1:0] r_cnt     [nrOfChannels];
   logic [counterWidth-1:0] w_cnt_nxt [nrOfChannels];
   logic [nrOfChannels-1:0] r_expired;
   logic [nrOfChannels-1:0] w_expired_nxt;
   logic [3:0]              r_wch;
   logic [31:0]             r_result;
   logic [31:0]             w_result;

   logic [3:0]              w_op;
   logic [3:0]              w_ch;
   logic [counterWidth-1:0] w_a;
   logic                    w_accept;
   logic                    w_ch_ok;
   logic [counterWidth-1:0] w_sel_cnt;
   logic                    w_watch_hit;
   logic                    w_load_en;
   logic [counterWidth-1:0] w_load_val;
   logic                    w_start;
   logic                    w_status_clr;
   logic                    w_per_clr;
   logic                    w_unused;

`ifdef TIMER_BANK_PERIODIC_EN
   logic [nrOfChannels-1:0] r_periodic;
   logic [counterWidth-1:0] r_reload [nrOfChannels];
   logic                    w_per_set;
`endif

   assign w_op     = ciValueB[3:0];
   assign w_ch     = ciValueB[11:8];
   assign w_a      = ciValueA[counterWidth-1:0];
   assign w_accept = ciStart & ciCke & (ciN == customInstructionId) & (r_state == S_IDLE);
   assign w_ch_ok  = (32'(w_ch) < 32'(nrOfChannels));
   assign w_tick   = (r_pre == '0);
   assign ciDone   = (r_state == S_DONE);
   assign ciResult = r_result;
`ifdef TIMER_BANK_PERIODIC_EN
   assign w_unused = ^{ciValueA, ciValueB[31:12], ciValueB[7:4]};
`else
   assign w_unused = ^{ciValueA, ciValueB[31:12], ciValueB[7:4], w_per_clr};
`endif

   // Addressed channel and the blocked-on channel, selected without out-of-range array indexing.
   always_comb begin
      w_sel_cnt   = '0;
      w_watch_hit = 1'b0;
      for (int i = 0; i < nrOfChannels; i++) begin
         if (w_ch == 4'(i)) w_sel_cnt = r_cnt[i];
         if ((r_wch == 4'(i)) && w_tick && (r_cnt[i] == CNT_ONE)) w_watch_hit = 1'b1;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_result     = '0;
      w_load_en    = 1'b0;
      w_load_val   = '0;
      w_start      = 1'b0;
      w_status_clr = 1'b0;
      w_per_clr    = 1'b0;
`ifdef TIMER_BANK_PERIODIC_EN
      w_per_set    = 1'b0;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = S_DONE;
               if ((w_op != OP_STATUS) && !w_ch_ok) begin
                  w_result = '1;
               end else begin
                  case (w_op)
                     OP_WAIT: begin
                        if (w_a != '0) begin
                           w_load_en  = 1'b1;
                           w_load_val = w_a;
                           w_next     = S_BLOCK;
                        end
                     end
                     OP_START: begin
                        w_load_en  = 1'b1;
                        w_load_val = w_a;
                        w_start    = 1'b1;
                        w_per_clr  = 1'b1;
                     end
                     OP_READ:   w_result = 32'(w_sel_cnt);
                     OP_JOIN: begin
                        if (w_sel_cnt != '0) w_next = S_BLOCK;
                     end
                     OP_CANCEL: begin
                        w_result  = 32'(w_sel_cnt);
                        w_load_en = 1'b1;
                        w_per_clr = 1'b1;
                     end
                     OP_STATUS: begin
                        w_result     = 32'(r_expired);
                        w_status_clr = 1'b1;
                     end
`ifdef TIMER_BANK_PERIODIC_EN
                     OP_PERIODIC: begin
                        w_load_en = 1'b1;
                        if (w_a == '0) begin
                           w_result  = 32'(w_sel_cnt);
                           w_per_clr = 1'b1;
                        end else begin
                           w_load_val = w_a;
                           w_per_set  = 1'b1;
                        end
                     end
`endif
                     default:   w_result = '1;
                  endcase
               end
            end
         end
         S_BLOCK: begin
            if (w_watch_hit) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A command write to a channel overrides that channel's tick, so load/cancel beat expiry.
   always_comb begin
      w_cnt_nxt     = r_cnt;
      w_expired_nxt = w_status_clr ? '0 : r_expired;
      for (int i = 0; i < nrOfChannels; i++) begin
         if (w_load_en && (w_ch == 4'(i))) begin
            w_cnt_nxt[i] = w_load_val;
            if (w_start) w_expired_nxt[i] = 1'b0;
         end else if (w_tick && (r_cnt[i] != '0)) begin
            if (r_cnt[i] == CNT_ONE) begin
               w_expired_nxt[i] = 1'b1;
`ifdef TIMER_BANK_PERIODIC_EN
               w_cnt_nxt[i] = r_periodic[i] ? r_reload[i] : '0;
`else
               w_cnt_nxt[i] = '0;
`endif
            end else begin
               w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pre     <= PRE_RELOAD;
         r_result  <= '0;
         r_wch     <= '0;
         r_expired <= '0;
         for (int i = 0; i < nrOfChannels; i++) r_cnt[i] <= '0;
      end else begin
         r_state   <= w_next;
         r_pre     <= w_tick ? PRE_RELOAD : (r_pre - PRE_ONE);
         r_result  <= (w_next == S_DONE) ? w_result : '0;
         r_expired <= w_expired_nxt;
         if (w_accept) r_wch <= w_ch;
         for (int i = 0; i < nrOfChannels; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end

`ifdef TIMER_BANK_PERIODIC_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         r_periodic <= '0;
         for (int i = 0; i < nrOfChannels; i++) r_reload[i] <= '0;
      end else begin
         for (int i = 0; i < nrOfChannels; i++) begin
            if (w_load_en && (w_ch == 4'(i))) begin
               if (w_per_set) begin
                  r_periodic[i] <= 1'b1;
                  r_reload[i]   <= w_load_val;
               end else if (w_per_clr) begin
                  r_periodic[i] <= 1'b0;
               end
            end
         end
      end
   end
`endif

endmodule
